// File: rtl/countdown_ctrl_if.sv
// Bundle between the countdown controller and the digit chain / button board.
//   master : controller side (takes buttons + all_zero, drives ce/load/stop/state/alarm)
//   slave  : chain / board side (drives buttons + all_zero, observes the controls)
//   btn_start, btn_pause, btn_clear : raw, asynchronous, bouncy push-buttons
//   all_zero : 1 when every digit counter of the chain is 0
//   ce       : one-cycle count enable to the units digit
//   load     : one-cycle preset reload pulse to the digits
//   stop     : level that forces and holds the digits at zero
//   state    : 00 IDLE, 01 RUN, 10 PAUSED, 11 DONE
//   alarm    : alarm indicator
interface countdown_ctrl_if;
    logic       btn_start;
    logic       btn_pause;
    logic       btn_clear;
    logic       all_zero;
    logic       ce;
    logic       load;
    logic       stop;
    logic [1:0] state;
    logic       alarm;

    modport master (
        input  btn_start, btn_pause, btn_clear, all_zero,
        output ce, load, stop, state, alarm
    );

    modport slave (
        output btn_start, btn_pause, btn_clear, all_zero,
        input  ce, load, stop, state, alarm
    );
endinterface

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: run/pause controller and 1 Hz timebase for the countdown
// timer's digit chain. Debounces start/pause/clear, runs the prescaler, drives
// ce/load/stop into the units digit and flags the alarm at terminal count.
// Ports:
//   i_clk   : system clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : countdown_ctrl_if.master (buttons, all_zero, ce, load, stop, state, alarm)
// Build option: define ALARM_BLINK_EN to make the alarm blink at half the tick
// rate while DONE; otherwise alarm is a steady (state == DONE).
module countdown_ctrl #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    countdown_ctrl_if.master bus
);
    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam int PW       = $clog2(PRESCALE);
    localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int NUM_BTN  = 3;
    localparam int B_START  = 0;
    localparam int B_PAUSE  = 1;
    localparam int B_CLEAR  = 2;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_PAUSED = 2'b10;
    localparam logic [1:0] S_DONE   = 2'b11;

    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_press;

    assign w_raw = {bus.btn_clear, bus.btn_pause, bus.btn_start};

    // Per-button synchroniser + debouncer. r_cnt counts consecutive cycles the
    // synchronised level disagrees with the debounced one; the level flips on
    // the DEBOUNCE_CYCLES-th such cycle and a rising flip emits one press.
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        logic          r_s1;
        logic          r_s2;
        logic          r_db;
        logic          r_press;
        logic [DW-1:0] r_cnt;

        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_db    <= 1'b0;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1    <= w_raw[g];
                r_s2    <= r_s1;
                r_press <= 1'b0;
                if (r_s2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_MAX) begin
                    r_cnt   <= '0;
                    r_db    <= r_s2;
                    r_press <= r_s2;
                end else begin
                    r_cnt <= r_cnt + DW'(1);
                end
            end
        end

        assign w_press[g] = r_press;
    end

    logic          w_clr;
    logic          w_pause;
    logic          w_start;
    logic          w_wrap;
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [PW-1:0] r_pre;
    logic          r_load;
    logic          r_load_pend;

    assign w_clr   = w_press[B_CLEAR];
    assign w_pause = w_press[B_PAUSE];
    assign w_start = w_press[B_START];
    assign w_wrap  = (r_pre == PRE_MAX);

    // Clear outranks everything; in RUN, terminal count outranks pause.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_clr)        w_state_nxt = S_IDLE;
                else if (w_start) w_state_nxt = bus.all_zero ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_clr)             w_state_nxt = S_IDLE;
                else if (bus.all_zero) w_state_nxt = S_DONE;
                else if (w_pause)      w_state_nxt = S_PAUSED;
            end
            S_PAUSED: begin
                if (w_clr)        w_state_nxt = S_IDLE;
                else if (w_start) w_state_nxt = S_RUN;
            end
            default: begin
                if (w_clr) w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_pre       <= '0;
            r_load      <= 1'b0;
            r_load_pend <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            // load_pend gives the chain a preset load right after reset release
            r_load      <= r_load_pend | w_clr;
            r_load_pend <= 1'b0;
            // PAUSED and IDLE hold the phase so a resume keeps its position
            if (w_clr || (r_state == S_IDLE && w_start))
                r_pre <= '0;
            else if (r_state == S_RUN || r_state == S_DONE)
                r_pre <= w_wrap ? '0 : r_pre + PW'(1);
        end
    end

    // all_zero masks ce so the chain never wraps below zero
    assign bus.ce    = w_wrap & (r_state == S_RUN) & ~bus.all_zero;
    assign bus.load  = r_load;
    assign bus.stop  = (r_state == S_DONE);
    assign bus.state = r_state;

`ifdef ALARM_BLINK_EN
    logic r_alarm;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)                    r_alarm <= 1'b0;
        else if (w_state_nxt != S_DONE)  r_alarm <= 1'b0;
        else if (r_state != S_DONE)      r_alarm <= 1'b1;
        else if (w_wrap)                 r_alarm <= ~r_alarm;
    end

    assign bus.alarm = r_alarm;
`else
    assign bus.alarm = (r_state == S_DONE);
`endif
endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl (PRESCALE=20, DEBOUNCE_CYCLES=4). A behavioural
// model tracks mode/phase/button history per clock; each test task drives its
// scenario and compares the DUT against the model plus spec-level properties.
module tb_countdown_ctrl;
    localparam int CLK_HZ = 20;
    localparam int TICK_HZ = 1;
    localparam int DB = 4;
    localparam int P = CLK_HZ / TICK_HZ;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    countdown_ctrl_if bus();

    countdown_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_CYCLES(DB)) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // mode uses the LED code: 0 IDLE, 1 RUN, 2 PAUSED, 3 DONE
    int       m_mode = 0;
    int       m_phase = 0;
    bit       m_pend = 1'b1;
    bit       m_load = 1'b0;
    bit       m_alarm = 1'b0;
    bit [2:0] m_press = '0;
    bit [2:0] m_s1 = '0;
    bit [2:0] m_s2 = '0;
    bit [2:0] m_db = '0;
    bit [2:0] m_hist [DB];

    always @(posedge clk or negedge rst_n) begin
        bit clr, pau, st, differ_all;
        int nm;
        if (!rst_n) begin
            m_mode = 0; m_phase = 0; m_pend = 1'b1; m_load = 1'b0; m_alarm = 1'b0;
            m_press = '0; m_s1 = '0; m_s2 = '0; m_db = '0;
            for (int k = 0; k < DB; k++) m_hist[k] = '0;
        end else begin
            clr = m_press[2]; pau = m_press[1]; st = m_press[0];
            nm = m_mode;
            if (clr) nm = 0;
            else if (m_mode == 0 && st) nm = bus.all_zero ? 3 : 1;
            else if (m_mode == 1 && bus.all_zero) nm = 3;
            else if (m_mode == 1 && pau) nm = 2;
            else if (m_mode == 2 && st) nm = 1;
            m_load = m_pend | clr;
            m_pend = 1'b0;
            if (nm != 3) m_alarm = 1'b0;
            else if (m_mode != 3) m_alarm = 1'b1;
            else if (m_phase == P - 1) m_alarm = ~m_alarm;
            if (clr || (m_mode == 0 && st)) m_phase = 0;
            else if (m_mode == 1 || m_mode == 3) m_phase = (m_phase + 1) % P;
            m_mode = nm;
            // debounced level flips once the last DB synchronised samples all disagree
            for (int k = DB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = m_s2;
            m_press = '0;
            for (int b = 0; b < 3; b++) begin
                differ_all = 1'b1;
                for (int k = 0; k < DB; k++) if (m_hist[k][b] == m_db[b]) differ_all = 1'b0;
                if (differ_all) begin
                    m_db[b] = ~m_db[b];
                    m_press[b] = m_db[b];
                end
            end
            m_s2 = m_s1;
            m_s1 = {bus.btn_clear, bus.btn_pause, bus.btn_start};
        end
    end

    function automatic logic [5:0] exp_vec();
        logic ce_e;
        logic al;
        logic [1:0] st;
        ce_e = (m_mode == 1) && (m_phase == P - 1) && !bus.all_zero;
        st = m_mode[1:0];
`ifdef ALARM_BLINK_EN
        al = m_alarm;
`else
        al = (m_mode == 3);
`endif
        return {ce_e, m_load, (m_mode == 3), st, al};
    endfunction

    function automatic logic [5:0] obs_vec();
        return {bus.ce, bus.load, bus.stop, bus.state, bus.alarm};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== 6'b0) begin errors++; $display("FAIL reset_hold got %b want %b", obs_vec(), 6'b0); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.load, bus.state, bus.ce, bus.stop} !== 5'b10000) begin
            errors++; $display("FAIL reset_load got %b want %b", {bus.load, bus.state, bus.ce, bus.stop}, 5'b10000);
        end
        @(negedge clk);
        checks++;
        if (bus.load !== 1'b0) begin errors++; $display("FAIL reset_load_once got %b want 0", bus.load); end
    endtask

    task automatic test_start();
        int dur, run_cnt, nce;
        dur = $urandom_range(8, 14);
        run_cnt = 0; nce = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL start c%0d got %b want %b", i, obs_vec(), exp_vec()); end
            if (bus.state === 2'b01) run_cnt++;
            if (bus.ce === 1'b1) begin
                nce++;
                checks++;
                if (run_cnt != P) begin errors++; $display("FAIL start_ce_period got %0d want %0d", run_cnt, P); end
                run_cnt = 0;
            end
            bus.btn_start = (i < dur);
        end
        checks++;
        if (bus.state !== 2'b01 || nce < 2) begin errors++; $display("FAIL start_run got state %b ce %0d want 01 >=2", bus.state, nce); end
    endtask

    task automatic test_pause();
        int d, run_cnt, nce;
        bit seen;
        d = $urandom_range(0, 19);
        run_cnt = 0; nce = 0; seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL pause c%0d got %b want %b", i, obs_vec(), exp_vec()); end
            if (i >= 40 && i < 90) begin
                checks++;
                if (bus.state !== 2'b10 || bus.ce !== 1'b0) begin
                    errors++; $display("FAIL pause_hold c%0d got state %b ce %b want 10 0", i, bus.state, bus.ce);
                end
            end
            if (bus.state === 2'b01) run_cnt++;
            if (bus.ce === 1'b1) begin
                if (i >= 90) nce++;
                if (seen) begin
                    checks++;
                    if (run_cnt != P) begin errors++; $display("FAIL pause_phase got %0d want %0d", run_cnt, P); end
                end
                seen = 1'b1;
                run_cnt = 0;
            end
            bus.btn_pause = (i >= d && i < d + 10);
            bus.btn_start = (i >= 90 && i < 100);
        end
        checks++;
        if (nce < 2) begin errors++; $display("FAIL pause_resume got %0d ce want >=2", nce); end
    endtask

    task automatic test_all_zero();
        int d;
        d = $urandom_range(0, 25);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL allzero c%0d got %b want %b", i, obs_vec(), exp_vec()); end
            if (i > d) begin
                checks++;
                if ({bus.state, bus.stop, bus.ce, bus.load} !== 5'b11100) begin
                    errors++; $display("FAIL allzero_done c%0d got %b want %b", i, {bus.state, bus.stop, bus.ce, bus.load}, 5'b11100);
                end
            end
            if (i == d + 1) begin
                checks++;
                if (bus.alarm !== 1'b1) begin errors++; $display("FAIL allzero_alarm got %b want 1", bus.alarm); end
            end
            if (i == d) begin
                bus.all_zero = 1'b1;
                #1;
                checks++;
                if (bus.ce !== 1'b0) begin errors++; $display("FAIL allzero_ce got %b want 0", bus.ce); end
            end
            bus.btn_start = (i >= 40 && i < 50);
            bus.btn_pause = (i >= 55 && i < 65);
        end
    endtask

    task automatic test_done_clear();
        int nload;
        nload = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL doneclr c%0d got %b want %b", i, obs_vec(), exp_vec()); end
            if (bus.load === 1'b1) begin
                nload++;
                checks++;
                if ({bus.state, bus.stop, bus.alarm} !== 4'b0000) begin
                    errors++; $display("FAIL doneclr_load got %b want 0000", {bus.state, bus.stop, bus.alarm});
                end
                bus.all_zero = 1'b0;
            end
            if (i >= 34 && i < 60) begin
                checks++;
                if (bus.state !== 2'b00) begin errors++; $display("FAIL bounce c%0d got %b want 00", i, bus.state); end
            end
            bus.btn_clear = (i < 10);
            bus.btn_start = (i >= 30 && i < 33) || (i >= 60 && i < 70);
        end
        checks++;
        if (nload != 1 || bus.state !== 2'b01) begin
            errors++; $display("FAIL doneclr_end got load %0d state %b want 1 01", nload, bus.state);
        end
    endtask

    task automatic test_clear_start();
        int d, nload, run_cnt;
        bit seen;
        d = $urandom_range(5, 25);
        nload = 0; run_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL clrstart c%0d got %b want %b", i, obs_vec(), exp_vec()); end
            if (bus.state === 2'b01) run_cnt++;
            if (bus.load === 1'b1) begin
                nload++;
                checks++;
                if (bus.state !== 2'b00) begin errors++; $display("FAIL clrstart_idle got %b want 00", bus.state); end
                seen = 1'b1;
                run_cnt = 0;
            end
            if (bus.ce === 1'b1) begin
                if (seen) begin
                    checks++;
                    if (run_cnt != P) begin errors++; $display("FAIL clrstart_pre got %0d want %0d", run_cnt, P); end
                end
                run_cnt = 0;
            end
            bus.btn_clear = (i >= d && i < d + 10);
            bus.btn_start = (i >= d && i < d + 10) || (i >= 50 && i < 60);
        end
        checks++;
        if (nload != 1) begin errors++; $display("FAIL clrstart_load got %0d want 1", nload); end
    endtask

    task automatic test_idle_allzero();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL idlezero c%0d got %b want %b", i, obs_vec(), exp_vec()); end
            if (i >= 25 && i < 60) begin
                checks++;
                if (bus.state === 2'b01) begin errors++; $display("FAIL idlezero_run c%0d got %b want not 01", i, bus.state); end
            end
            if (i == 59) begin
                checks++;
                if (bus.state !== 2'b11) begin errors++; $display("FAIL idlezero_done got %b want 11", bus.state); end
            end
            if (i == 20) bus.all_zero = 1'b1;
            if (i == 85) bus.all_zero = 1'b0;
            bus.btn_clear = (i < 10) || (i >= 60 && i < 70);
            bus.btn_start = (i >= 30 && i < 40);
        end
    endtask

    task automatic test_reset_midrun();
        int d;
        d = $urandom_range(20, 45);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL midrun c%0d got %b want %b", i, obs_vec(), exp_vec()); end
            bus.btn_start = (i < 10);
            if (i == d) break;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 6'b0) begin errors++; $display("FAIL midrun_abort got %b want %b", obs_vec(), 6'b0); end
        bus.btn_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL midrun_rel c%0d got %b want %b", i, obs_vec(), exp_vec()); end
            if (i == 2) rst_n = 1'b1;
        end
    endtask

    task automatic test_random();
        int hold [3];
        int az_hold;
        logic [2:0] lvl;
        lvl = '0; az_hold = 0;
        for (int b = 0; b < 3; b++) hold[b] = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL random c%0d got %b want %b", i, obs_vec(), exp_vec()); end
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    case (b)
                        0: lvl[b] = ($urandom_range(0, 1) == 0);
                        1: lvl[b] = ($urandom_range(0, 3) == 0);
                        default: lvl[b] = ($urandom_range(0, 7) == 0);
                    endcase
                    hold[b] = $urandom_range(1, 12);
                end
                hold[b]--;
            end
            if (az_hold == 0) begin
                bus.all_zero = ($urandom_range(0, 3) == 0);
                az_hold = $urandom_range(10, 60);
            end
            az_hold--;
            bus.btn_start = lvl[0];
            bus.btn_pause = lvl[1];
            bus.btn_clear = lvl[2];
        end
        bus.btn_start = 1'b0; bus.btn_pause = 1'b0; bus.btn_clear = 1'b0; bus.all_zero = 1'b0;
    endtask

    initial begin
        bus.btn_start = 1'b0;
        bus.btn_pause = 1'b0;
        bus.btn_clear = 1'b0;
        bus.all_zero  = 1'b0;
        test_reset();
        test_start();
        test_pause();
        test_all_zero();
        test_done_clear();
        test_clear_start();
        test_idle_allzero();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
